router_out_reader: RTL

Destination-side consumer for one router output channel. Watches the channel's valid-out, issues read enables to the output FIFO, de-frames each packet (header, payload, parity), and presents payload bytes, length and error status to the local client. It always drains a non-empty channel well inside the router's 30-cycle read timeout, so the router's soft reset fires only under fault.

---
 rtl/router_out_reader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/router_out_reader.sv
// router_out_reader: drains one router output channel and de-frames header/payload/parity
// packets for the local client. Define ROUTER_READER_PARITY_CHK_EN to enable the parity check.
module router_out_reader #(
  parameter logic [1:0] PORT_ADDR  = 2'b00,
  parameter int         READ_DELAY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic [7:0] pkt_data,
  output logic       pkt_data_vld,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       addr_err,
  output logic       pkt_abort,
  output logic       busy
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] HDR_REQ = 3'd2;
  localparam logic [2:0] HDR_CAP = 3'd3;
  localparam logic [2:0] BODY    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  if (READ_DELAY < 0 || READ_DELAY > 20) begin : g_bad_read_delay
    $error("router_out_reader: READ_DELAY must be within 0..20");
  end

  // WAIT occupies exactly READ_DELAY cycles: the counter runs READ_DELAY-1 down to 0.
  localparam logic [4:0] WAIT_INIT = (READ_DELAY > 0) ? 5'(READ_DELAY - 1) : 5'd0;

  logic [2:0] state_q, state_d;
  logic [4:0] wait_cnt_q, wait_cnt_d;
  logic [6:0] req_left_q, req_left_d;
  logic [5:0] rx_cnt_q, rx_cnt_d;
  logic [5:0] len_q, len_d;
  logic       addr_mis_q, addr_mis_d;
  logic       rd_q;
  logic [7:0] data_q, data_d;
  logic       data_vld_q, data_vld_d;
  logic       done_q, done_d;
  logic       addr_err_q, addr_err_d;
  logic       abort_q, abort_d;
`ifdef ROUTER_READER_PARITY_CHK_EN
  logic [7:0] acc_q, acc_d;
  logic       err_q, err_d;
`endif

  logic abort_now;
  logic byte_in;
  logic last_byte;

  assign abort_now = soft_reset && (state_q != IDLE);
  // A byte is on data_out exactly one cycle after each read issued from BODY.
  assign byte_in   = (state_q == BODY) && rd_q;
  assign last_byte = (rx_cnt_q == len_q);

  assign read_enb = !soft_reset &&
                    ((state_q == HDR_REQ) ||
                     ((state_q == BODY) && vld_out && (req_left_q != 7'd0)));

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    req_left_d = req_left_q;
    rx_cnt_d   = rx_cnt_q;
    len_d      = len_q;
    addr_mis_d = addr_mis_q;
    data_d     = data_q;
    data_vld_d = 1'b0;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    abort_d    = 1'b0;
`ifdef ROUTER_READER_PARITY_CHK_EN
    acc_d      = acc_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (vld_out) begin
          state_d    = (READ_DELAY > 0) ? WAIT : HDR_REQ;
          wait_cnt_d = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == 5'd0) state_d = HDR_REQ;
        else                    wait_cnt_d = wait_cnt_q - 5'd1;
      end
      HDR_REQ: state_d = HDR_CAP;
      HDR_CAP: begin
        len_d      = data_out[7:2];
        addr_mis_d = (data_out[1:0] != PORT_ADDR);
        req_left_d = {1'b0, data_out[7:2]} + 7'd1;
        rx_cnt_d   = 6'd0;
`ifdef ROUTER_READER_PARITY_CHK_EN
        acc_d      = data_out;
`endif
        state_d    = BODY;
      end
      BODY: begin
        if (read_enb) req_left_d = req_left_q - 7'd1;
        if (byte_in) begin
          if (!last_byte) begin
            data_d     = data_out;
            data_vld_d = 1'b1;
            rx_cnt_d   = rx_cnt_q + 6'd1;
`ifdef ROUTER_READER_PARITY_CHK_EN
            acc_d      = acc_q ^ data_out;
`endif
          end else begin
            done_d     = 1'b1;
            addr_err_d = addr_mis_q;
`ifdef ROUTER_READER_PARITY_CHK_EN
            err_d      = (acc_q != data_out);
`endif
            state_d    = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A channel flush drops the packet in flight; nothing is reported for it but the abort.
    if (abort_now) begin
      state_d    = IDLE;
      abort_d    = 1'b1;
      data_vld_d = 1'b0;
      done_d     = 1'b0;
      addr_err_d = 1'b0;
`ifdef ROUTER_READER_PARITY_CHK_EN
      err_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= 5'd0;
      req_left_q <= 7'd0;
      rx_cnt_q   <= 6'd0;
      len_q      <= 6'd0;
      addr_mis_q <= 1'b0;
      rd_q       <= 1'b0;
      data_q     <= 8'd0;
      data_vld_q <= 1'b0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      req_left_q <= req_left_d;
      rx_cnt_q   <= rx_cnt_d;
      len_q      <= len_d;
      addr_mis_q <= addr_mis_d;
      rd_q       <= read_enb;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      abort_q    <= abort_d;
    end
  end

`ifdef ROUTER_READER_PARITY_CHK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      err_q <= err_d;
    end
  end
  assign pkt_err = err_q;
`else
  assign pkt_err = 1'b0;
`endif

  assign pkt_data     = data_q;
  assign pkt_data_vld = data_vld_q;
  assign pkt_len      = len_q;
  assign pkt_done     = done_q;
  assign addr_err     = addr_err_q;
  assign pkt_abort    = abort_q;
  assign busy         = (state_q != IDLE);

endmodule
